// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, port ids and request type for the memory arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } portIdT;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } memReqT;

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational winner select between CPU and DMA requests
// Optional ARB_ROUND_ROBIN_EN: ties go to the port that did not win last; otherwise CPU wins ties.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   cpuElig,
    input  logic   dmaElig,
    input  portIdT lastGrant,
    output logic   pickValid,
    output portIdT pickPort
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant;
`endif

    always_comb begin
        pickValid = cpuElig | dmaElig;
        pickPort  = PORT_CPU;
        if (cpuElig && dmaElig) begin
`ifdef ARB_ROUND_ROBIN_EN
            pickPort = (lastGrant == PORT_CPU) ? PORT_DMA : PORT_CPU;
`else
            pickPort = PORT_CPU;
`endif
        end else if (dmaElig) begin
            pickPort = PORT_DMA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port (CPU/DMA) arbiter onto a single synchronous block RAM
// Optional ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed CPU priority.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              armed;
    portIdT            lastGrant;
    logic              rdPendQ;
    portIdT            rdTagQ;
    logic [DATA_W-1:0] cpuRdataQ;
    logic [DATA_W-1:0] dmaRdataQ;

    logic              cpuElig;
    logic              dmaElig;
    logic              pickValid;
    portIdT            pickPort;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // A port whose grant is showing this cycle is masked so a held request cannot re-issue.
    assign cpuElig = armed & cpu_req & ~cpu_gnt;
    assign dmaElig = armed & dma_req & ~dma_gnt;

    mem_arb_picker u_picker (
        .cpuElig   (cpuElig),
        .dmaElig   (dmaElig),
        .lastGrant (lastGrant),
        .pickValid (pickValid),
        .pickPort  (pickPort)
    );

    always_comb begin
        selWe    = cpu_we;
        selAddr  = cpu_addr;
        selWdata = cpu_wdata;
        if (pickPort == PORT_DMA) begin
            selWe    = dma_we;
            selAddr  = dma_addr;
            selWdata = dma_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            lastGrant <= PORT_DMA;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdPendQ   <= 1'b0;
            rdTagQ    <= PORT_CPU;
            cpuRdataQ <= '0;
            dmaRdataQ <= '0;
        end else begin
            // First edge after reset only arms; issue is possible from the second edge on.
            armed   <= 1'b1;
            cpu_gnt <= pickValid && (pickPort == PORT_CPU);
            dma_gnt <= pickValid && (pickPort == PORT_DMA);
            mem_cs  <= pickValid;
            mem_we  <= pickValid & selWe;
            if (pickValid) begin
                mem_addr  <= selAddr;
                mem_wdata <= selWdata;
                lastGrant <= pickPort;
            end
            rdPendQ <= mem_cs & ~mem_we;
            rdTagQ  <= lastGrant;
            if (cpu_rvalid) begin
                cpuRdataQ <= mem_rdata;
            end
            if (dma_rvalid) begin
                dmaRdataQ <= mem_rdata;
            end
        end
    end

    // RAM data is live in the rvalid cycle; the held copy covers the gaps.
    assign cpu_rvalid = rdPendQ && (rdTagQ == PORT_CPU);
    assign dma_rvalid = rdPendQ && (rdTagQ == PORT_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpuRdataQ;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dmaRdataQ;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int   testCount = 0;
    int   failCount = 0;
    logic expCpu;
    logic sawRvalid;
    int   gntCount;
    int   issueCount;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous block RAM: read data appears one clock after the access.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveCpu(input logic req, input memReqT r);
        cpu_req   = req;
        cpu_we    = r.we;
        cpu_addr  = r.addr;
        cpu_wdata = r.wdata;
    endtask

    task automatic driveDma(input logic req, input memReqT r);
        dma_req   = req;
        dma_we    = r.we;
        dma_addr  = r.addr;
        dma_wdata = r.wdata;
    endtask

    function automatic logic [43:0] allOuts();
        return {mem_cs, mem_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid,
                mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    endfunction

    initial begin
        reset = 1'b1;
        mem_rdata = '0;
        driveCpu(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        driveDma(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        ram[14'h0123] = 8'h5A;
        ram[14'h0010] = 8'h11;
        ram[14'h0020] = 8'h22;

        repeat (3) @(negedge clk);
        checkEq("rst_all_outputs", allOuts(), 44'h0);

        // CPU read; first issue only at the second edge after reset release
        reset = 1'b0;
        driveCpu(1'b1, memReqT'{1'b0, 14'h0123, 8'h00});
        @(negedge clk);
        checkEq("first_edge_no_gnt", cpu_gnt, 1'b0);
        @(negedge clk);
        checkEq("cpu_rd_gnt", {cpu_gnt, dma_gnt, mem_cs, mem_we}, 4'b1010);
        checkEq("cpu_rd_addr", mem_addr, 14'h0123);
        driveCpu(1'b0, memReqT'{1'b0, 14'h0123, 8'h00});
        @(negedge clk);
        checkEq("cpu_rd_rvalid", {cpu_rvalid, dma_rvalid, cpu_gnt}, 3'b100);
        checkEq("cpu_rd_rdata", cpu_rdata, 8'h5A);
        @(negedge clk);
        checkEq("cpu_rd_idle", {cpu_rvalid, mem_cs, mem_we}, 3'b000);
        checkEq("cpu_rdata_hold", cpu_rdata, 8'h5A);

        // DMA write then CPU read of the top address
        driveDma(1'b1, memReqT'{1'b1, 14'h3FFF, 8'hC3});
        @(negedge clk);
        checkEq("dma_wr_gnt", {dma_gnt, cpu_gnt, mem_cs, mem_we}, 4'b1011);
        checkEq("dma_wr_addr", mem_addr, 14'h3FFF);
        checkEq("dma_wr_data", mem_wdata, 8'hC3);
        driveDma(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        @(negedge clk);
        checkEq("dma_wr_no_rvalid", {dma_rvalid, cpu_rvalid, mem_cs}, 3'b000);
        driveCpu(1'b1, memReqT'{1'b0, 14'h3FFF, 8'h00});
        @(negedge clk);
        checkEq("cpu_rd2_gnt", {cpu_gnt, mem_we, mem_addr}, {2'b10, 14'h3FFF});
        driveCpu(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        @(negedge clk);
        checkEq("cpu_rd2_rvalid", {cpu_rvalid, dma_rvalid}, 2'b10);
        checkEq("cpu_rd2_rdata", cpu_rdata, 8'hC3);
        checkEq("dma_rdata_untouched", dma_rdata, 8'h00);
        @(negedge clk);

        // Both ports continuously; last grant was CPU, so the tie-break decides cycle 0
        driveCpu(1'b1, memReqT'{1'b0, 14'h0010, 8'h00});
        driveDma(1'b1, memReqT'{1'b0, 14'h0020, 8'h00});
        expCpu = !RR;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkEq($sformatf("alt_gnt_%0d", k), {cpu_gnt, dma_gnt, mem_cs}, {expCpu, !expCpu, 1'b1});
            if (k > 0) begin
                checkEq($sformatf("alt_rvalid_%0d", k), {cpu_rvalid, dma_rvalid}, {!expCpu, expCpu});
                if (!expCpu) checkEq($sformatf("alt_cpu_rdata_%0d", k), cpu_rdata, 8'h11);
                else         checkEq($sformatf("alt_dma_rdata_%0d", k), dma_rdata, 8'h22);
            end
            expCpu = !expCpu;
        end
        driveCpu(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        driveDma(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        repeat (2) @(negedge clk);
        checkEq("alt_drained", {mem_cs, cpu_rvalid, dma_rvalid}, 3'b000);

        // Held CPU write request for 3 samples after its grant: gnt/issue at cycles 0 and 2
        gntCount   = 0;
        issueCount = 0;
        driveCpu(1'b1, memReqT'{1'b1, 14'h0050, 8'h77});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_gnt || dma_gnt) gntCount++;
            if (mem_cs)             issueCount++;
            if (i == 3) driveCpu(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        end
        checkEq("held_gnt_count", gntCount, 2);
        checkEq("held_issue_count", issueCount, 2);

        // Reset pulsed the cycle after a CPU read grant discards the read
        driveCpu(1'b1, memReqT'{1'b0, 14'h0123, 8'h00});
        @(negedge clk);
        checkEq("rst_mid_gnt", cpu_gnt, 1'b1);
        driveCpu(1'b0, memReqT'{1'b0, 14'h0000, 8'h00});
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkEq("rst_mid_outputs", allOuts(), 44'h0);
        @(negedge clk);
        reset = 1'b0;
        sawRvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sawRvalid = sawRvalid | cpu_rvalid | dma_rvalid;
        end
        checkEq("rst_no_late_rvalid", sawRvalid, 1'b0);
        checkEq("rst_rdata_cleared", cpu_rdata, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: ADDR_W, 14, system RAM word-address width (16 kB).
REQ-002 Parameter: DATA_W, 8, data width.
REQ-003 Port: clk  input  1  single system clock; all logic rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: cpu_req  input  1  CPU access request; held high until cpu_gnt.
REQ-006 Port: cpu_we  input  1  CPU write (1) / read (0); stable while cpu_req is high.
REQ-007 Port: cpu_addr  input  ADDR_W  CPU address; stable while cpu_req is high.
REQ-008 Port: cpu_wdata  input  DATA_W  CPU write data.
REQ-009 Port: cpu_gnt  output  1  one-cycle pulse; CPU access issued to RAM this cycle.
REQ-010 Port: cpu_rvalid  output  1  one-cycle pulse; cpu_rdata valid.
REQ-011 Port: cpu_rdata  output  DATA_W  CPU read data.
REQ-012 Port: dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same directions, widths and meanings as the cpu_* ports, for the DMA/video requester.
REQ-013 Port: mem_cs  output  1  RAM chip select.
REQ-014 Port: mem_we  output  1  RAM write enable.
REQ-015 Port: mem_addr  output  ADDR_W  RAM address.
REQ-016 Port: mem_wdata  output  DATA_W  RAM write data.
REQ-017 Port: mem_rdata  input  DATA_W  RAM read data; valid one clock after a read issue (synchronous block RAM).

Function
REQ-018 Arbitration: sample requests at edge N; issue the winner at cycle N+1; mem_cs/mem_we/mem_addr/mem_wdata and the matching *_gnt are all registered.
REQ-019 At most one access issues per cycle; with no eligible request, mem_cs=0 and mem_we=0.
REQ-020 Mask out a port's req in the cycle its gnt is high; a held req therefore never double-issues.
REQ-021 Read latency: a read issued at cycle N+1 produces *_rvalid and *_rdata at N+2 on the issuing port only; a one-bit port tag and a valid bit pipeline alongside the RAM.
REQ-022 Writes produce no rvalid.
REQ-023 *_rdata holds its last captured value between rvalid pulses.
REQ-024 Back-to-back issue across ports is allowed: CPU at N+1 and DMA at N+2 is legal.
REQ-025 Per-port issue rate: at most one access every 2 cycles.
REQ-026 Priority without ARB_ROUND_ROBIN_EN: CPU beats DMA on simultaneous eligible requests.
REQ-027 A last_grant register records the port of every issue.

Reset
REQ-028 While reset is high: mem_cs, mem_we, cpu_gnt, dma_gnt, cpu_rvalid and dma_rvalid are 0; mem_addr, mem_wdata, cpu_rdata and dma_rdata are 0; last_grant=DMA, so the CPU wins the first tie.
REQ-029 Reset asserted mid-access discards the in-flight read; no rvalid is produced after reset releases.
REQ-030 The first issue is possible at the second rising edge after reset deasserts.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous eligible requests, the port that is not last_grant wins.
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: fixed CPU priority; last_grant is still maintained but unused for selection.

Structure
REQ-033 Package mem_arb_pkg holds ADDR_W/DATA_W defaults, the port-id enum (PORT_CPU=0, PORT_DMA=1) and the request struct {we, addr, wdata}.
REQ-034 One sub-module, mem_arb_picker: combinational winner selection from the masked requests and last_grant; all registers stay in memory_arbiter.

Verification
REQ-035 CPU read only: cpu_req=1, addr=0x0123, with RAM preloaded 0x5A there -> cpu_gnt at +1, mem_addr=0x0123, mem_we=0, cpu_rvalid at +2 with cpu_rdata=0x5A.
REQ-036 DMA write then CPU read of the same address 0x3FFF (data 0xC3) -> dma_gnt with mem_we=1, then cpu_rvalid with cpu_rdata=0xC3.
REQ-037 Both ports request continuously with ARB_ROUND_ROBIN_EN defined -> grants alternate CPU, DMA, CPU, DMA, ... with mem_cs=1 every cycle.
REQ-038 Same stimulus with the macro undefined -> CPU gnt every 2 cycles and DMA issues only in the CPU-masked cycles; no double issue for either port.
REQ-039 Reset pulsed the cycle after a CPU read gnt -> no cpu_rvalid, and all outputs are 0 during reset.
REQ-040 Held cpu_req across 3 cycles after gnt with the requester late to drop it -> exactly one issue per gnt-observed transaction; the scoreboard matches issue count to gnt count.
